alarm_controller: RTL and testbench
===================================

ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 SHALL have parameter NUM_ALARMS, 4, number of alarm slots (alarm_id width is 2 bits, so the maximum is 4).
REQ-002 SHALL have parameter RING_SECONDS, 60, seconds of ringing before auto-stop.
REQ-003 SHALL have parameter SNOOZE_SECONDS, 300, seconds of snooze before re-ring.
REQ-004 SHALL have one clock and an asynchronous active-high reset.
REQ-005 SHALL have ports:
- clk  in  1  system clock
- rst  in  1  async active-high reset
- sec_tick  in  1  one-clk pulse per second, aligned with time update
- hh_mm_ss  in  20  current 24h time: [3:0] s0, [6:4] s1, [10:7] m0, [13:11] m1, [17:14] h0, [19:18] h1
- set_alarm  in  1  level; write slot this cycle
- alarm_id  in  2  slot index for write
- stime_alarm  in  20  alarm time, same packing; [6:0] ignored
- alarm_en_in  in  1  enable bit written with slot
- snooze  in  1  one-clk pulse, user snooze
- stop  in  1  one-clk pulse, user stop
- ringing  out  1  alarm sounding
- snoozing  out  1  in snooze interval
- active_id  out  2  slot that triggered the current ring/snooze
- alarm_enabled  out  NUM_ALARMS  per-slot enable bits

Function
REQ-006 SHALL store per slot hh:mm (13 bits, hh_mm_ss[19:7] layout) plus an enable bit; write occurs on a clk edge when set_alarm=1, effective the next cycle.
REQ-007 SHALL declare a match when sec_tick=1, hh_mm_ss[6:0]=0, and hh_mm_ss[19:7] equals an enabled slot's stored value; if several slots match, the lowest index wins.
REQ-008 SHALL implement FSM states IDLE, RINGING, SNOOZE; ringing=1 only in RINGING, snoozing=1 only in SNOOZE.
REQ-009 IDLE: match -> RINGING next clk, active_id=matched index, ring counter cleared; ringing asserted exactly 1 clk after the matching tick cycle.
REQ-010 RINGING: stop -> IDLE; else snooze -> SNOOZE with snooze counter cleared; else each sec_tick increments ring counter, and the tick at count RING_SECONDS-1 -> IDLE.
REQ-011 SNOOZE: stop -> IDLE; snooze ignored; each sec_tick increments snooze counter, and the tick at count SNOOZE_SECONDS-1 -> RINGING with ring counter cleared, same active_id.
REQ-012 Priority within a cycle SHALL be: stop > write-disable of active slot > snooze > tick/timeout.
REQ-013 A write with alarm_en_in=0 to slot active_id while in RINGING or SNOOZE SHALL force IDLE next clk; writes to other slots SHALL not affect the FSM.
REQ-014 Matches while in RINGING or SNOOZE SHALL be ignored (no re-trigger, active_id unchanged).
REQ-015 Counters SHALL be sized $clog2(max) and SHALL never wrap; stop/snooze pulses in IDLE SHALL be no-ops.
REQ-016 active_id SHALL hold its last value in IDLE.

Reset
REQ-017 On rst=1 (asynchronous): FSM=IDLE, ringing=0, snoozing=0, active_id=0, all slot times=0, alarm_enabled=0, both counters=0.
REQ-018 Reset asserted mid-RINGING or mid-SNOOZE SHALL drop outputs immediately, without waiting for a clk edge.

Structure
REQ-019 Shared package SHALL hold the hh_mm_ss field bit-position constants and the FSM state enum (IDLE/RINGING/SNOOZE).
REQ-020 Slot registers and the priority matcher SHALL be one sub-module, alarm_slot_bank; FSM and counters stay in alarm_controller.

Verification
REQ-021 Write slot 1 = 07:30, enabled; drive 07:30:00 with tick -> ringing=1 next clk, active_id=1.
REQ-022 Ringing, no input for 60 ticks -> ringing falls after 60th tick; 59 ticks -> still 1.
REQ-023 Ringing, snooze pulse -> snoozing=1; 300 ticks later -> ringing=1, active_id unchanged; stop -> both 0.
REQ-024 Slots 0 and 2 both = 12:00, enabled; tick at 12:00:00 -> active_id=0; slot 2 disabled-only set -> no ring.
REQ-025 Tick at 07:30:01 with slot = 07:30 -> no ring; stop and snooze in same cycle while ringing -> IDLE.
REQ-026 Ringing; write slot active_id with en=0 -> IDLE next clk; assert rst mid-SNOOZE -> snoozing=0 asynchronously, alarm_enabled=0.

Source files
------------

// File: rtl/alarm_controller_pkg.sv
// Shared definitions for the alarm controller: time-field bit positions and FSM states.
// The packed time word is [19:18] h1, [17:14] h0, [13:11] m1, [10:7] m0, [6:4] s1, [3:0] s0.
package alarm_controller_pkg;

  localparam int S0_LSB   = 0;
  localparam int S0_MSB   = 3;
  localparam int S1_LSB   = 4;
  localparam int S1_MSB   = 6;
  localparam int M0_LSB   = 7;
  localparam int M0_MSB   = 10;
  localparam int M1_LSB   = 11;
  localparam int M1_MSB   = 13;
  localparam int H0_LSB   = 14;
  localparam int H0_MSB   = 17;
  localparam int H1_LSB   = 18;
  localparam int H1_MSB   = 19;

  localparam int SEC_LSB  = S0_LSB;
  localparam int SEC_MSB  = S1_MSB;
  localparam int HHMM_LSB = M0_LSB;
  localparam int HHMM_MSB = H1_MSB;
  localparam int HHMM_W   = HHMM_MSB - HHMM_LSB + 1;
  localparam int TIME_W   = H1_MSB + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_e;

endpackage

// File: rtl/alarm_controller_if.sv
// User/time-base bus of the alarm controller.
// The slave modport is the controller's view; the master modport drives it.
interface alarm_controller_if #(
  parameter int NUM_ALARMS = 4
);
  logic                  sec_tick;
  logic [19:0]           hh_mm_ss;
  logic                  set_alarm;
  logic [1:0]            alarm_id;
  logic [19:0]           stime_alarm;
  logic                  alarm_en_in;
  logic                  snooze;
  logic                  stop;
  logic                  ringing;
  logic                  snoozing;
  logic [1:0]            active_id;
  logic [NUM_ALARMS-1:0] alarm_enabled;

  modport slave (
    input  sec_tick, hh_mm_ss, set_alarm, alarm_id, stime_alarm, alarm_en_in, snooze, stop,
    output ringing, snoozing, active_id, alarm_enabled
  );

  modport master (
    output sec_tick, hh_mm_ss, set_alarm, alarm_id, stime_alarm, alarm_en_in, snooze, stop,
    input  ringing, snoozing, active_id, alarm_enabled
  );
endinterface

// File: rtl/alarm_controller_slot_bank.sv
// Alarm slot storage (hh:mm plus enable per slot) and the lowest-index-wins matcher.
// The matcher sees stored values only, so a write lands one cycle before it can match.
module alarm_slot_bank
  import alarm_controller_pkg::*;
#(
  parameter int NUM_ALARMS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_alarm,
  input  logic [1:0]            alarm_id,
  input  logic [HHMM_W-1:0]     stimeHhmm,
  input  logic                  alarm_en_in,
  input  logic                  sec_tick,
  input  logic                  secZero,
  input  logic [HHMM_W-1:0]     nowHhmm,
  output logic                  match,
  output logic [1:0]            matchId,
  output logic [NUM_ALARMS-1:0] alarm_enabled
);

  logic [HHMM_W-1:0]     slotTime_q [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] slotEn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slotTime_q[i] <= '0;
      end
      slotEn_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (set_alarm && (alarm_id == 2'(i))) begin
          slotTime_q[i] <= stimeHhmm;
          slotEn_q[i]   <= alarm_en_in;
        end
      end
    end
  end

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    match   = 1'b0;
    matchId = 2'd0;
    if (sec_tick && secZero) begin
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
        if (slotEn_q[i] && (slotTime_q[i] == nowHhmm)) begin
          match   = 1'b1;
          matchId = 2'(i);
        end
      end
    end
  end

  assign alarm_enabled = slotEn_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller top: ring/snooze FSM with second counters around the slot bank.
// Outputs decode the state register directly so an async reset silences them at once.
module alarm_controller
  import alarm_controller_pkg::*;
#(
  parameter int NUM_ALARMS     = 4,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300
) (
  input logic               clk,
  input logic               rst,
  alarm_controller_if.slave bus
);

  localparam int RING_W   = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
  localparam int SNOOZE_W = (SNOOZE_SECONDS > 1) ? $clog2(SNOOZE_SECONDS) : 1;

  alarm_state_e  state_q, state_d;
  logic [RING_W-1:0]   ringCnt_q, ringCnt_d;
  logic [SNOOZE_W-1:0] snoozeCnt_q, snoozeCnt_d;
  logic [1:0]    activeId_q, activeId_d;

  logic          match;
  logic [1:0]    matchId;
  logic          secZero;
  logic          disableActive;
  logic          unusedStimeSecs;

  assign secZero         = (bus.hh_mm_ss[SEC_MSB:SEC_LSB] == '0);
  assign unusedStimeSecs = ^bus.stime_alarm[SEC_MSB:SEC_LSB];

  alarm_slot_bank #(
    .NUM_ALARMS (NUM_ALARMS)
  ) u_slot_bank (
    .clk           (clk),
    .rst           (rst),
    .set_alarm     (bus.set_alarm),
    .alarm_id      (bus.alarm_id),
    .stimeHhmm     (bus.stime_alarm[HHMM_MSB:HHMM_LSB]),
    .alarm_en_in   (bus.alarm_en_in),
    .sec_tick      (bus.sec_tick),
    .secZero       (secZero),
    .nowHhmm       (bus.hh_mm_ss[HHMM_MSB:HHMM_LSB]),
    .match         (match),
    .matchId       (matchId),
    .alarm_enabled (bus.alarm_enabled)
  );

  assign disableActive = bus.set_alarm && !bus.alarm_en_in && (bus.alarm_id == activeId_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ringCnt_q   <= '0;
      snoozeCnt_q <= '0;
      activeId_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      ringCnt_q   <= ringCnt_d;
      snoozeCnt_q <= snoozeCnt_d;
      activeId_q  <= activeId_d;
    end
  end

  // Each branch's if/else chain encodes the in-cycle priority: stop, disable, snooze, tick.
  always_comb begin
    state_d     = state_q;
    ringCnt_d   = ringCnt_q;
    snoozeCnt_d = snoozeCnt_q;
    activeId_d  = activeId_q;
    unique case (state_q)
      IDLE: begin
        if (match) begin
          state_d    = RINGING;
          activeId_d = matchId;
          ringCnt_d  = '0;
        end
      end
      RINGING: begin
        if (bus.stop || disableActive) begin
          state_d = IDLE;
        end else if (bus.snooze) begin
          state_d     = SNOOZE;
          snoozeCnt_d = '0;
        end else if (bus.sec_tick) begin
          if (ringCnt_q == RING_W'(RING_SECONDS - 1)) begin
            state_d   = IDLE;
            ringCnt_d = '0;
          end else begin
            ringCnt_d = ringCnt_q + RING_W'(1);
          end
        end
      end
      SNOOZE: begin
        if (bus.stop || disableActive) begin
          state_d = IDLE;
        end else if (bus.sec_tick) begin
          if (snoozeCnt_q == SNOOZE_W'(SNOOZE_SECONDS - 1)) begin
            state_d     = RINGING;
            ringCnt_d   = '0;
            snoozeCnt_d = '0;
          end else begin
            snoozeCnt_d = snoozeCnt_q + SNOOZE_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ringing   = (state_q == RINGING);
  assign bus.snoozing  = (state_q == SNOOZE);
  assign bus.active_id = activeId_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: each step pushes its expected outputs to a
// scoreboard queue, and the entry is popped and compared once the clock edge has landed.
module tb_alarm_controller;
  import alarm_controller_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [7:0] expQ [$];
  string      tagQ [$];

  alarm_controller_if #(.NUM_ALARMS(4)) bus ();

  alarm_controller #(
    .NUM_ALARMS     (4),
    .RING_SECONDS   (60),
    .SNOOZE_SECONDS (300)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] hms(input int h, input int m, input int s);
    logic [19:0] t;
    t = '0;
    t[H1_MSB:H1_LSB] = 2'(h / 10);
    t[H0_MSB:H0_LSB] = 4'(h % 10);
    t[M1_MSB:M1_LSB] = 3'(m / 10);
    t[M0_MSB:M0_LSB] = 4'(m % 10);
    t[S1_MSB:S1_LSB] = 3'(s / 10);
    t[S0_MSB:S0_LSB] = 4'(s % 10);
    return t;
  endfunction

  // Expected-output word: {ringing, snoozing, active_id, alarm_enabled}.
  function automatic logic [7:0] ex(input logic r, input logic s, input logic [1:0] id,
                                    input logic [3:0] en);
    return {r, s, id, en};
  endfunction

  task automatic checkOutput();
    logic [7:0] obs;
    logic [7:0] e;
    string      tag;
    obs = {bus.ringing, bus.snoozing, bus.active_id, bus.alarm_enabled};
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_empty observed=%b expected=<entry>", obs);
    end else begin
      e   = expQ.pop_front();
      tag = tagQ.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("[TB] FAIL %s observed={r,s,id,en}=%b expected=%b", tag, obs, e);
      end
    end
  endtask

  task automatic checkNow(input string tag, input logic [7:0] e);
    tagQ.push_back(tag);
    expQ.push_back(e);
    checkOutput();
  endtask

  // Drive one clock's worth of inputs, record the expectation, then compare after the edge.
  task automatic applyStimulus(input string tag, input logic tick, input logic [19:0] t,
                               input logic set, input logic [1:0] id, input logic [19:0] st,
                               input logic en, input logic snz, input logic stp,
                               input logic [7:0] e);
    bus.sec_tick    = tick;
    bus.hh_mm_ss    = t;
    bus.set_alarm   = set;
    bus.alarm_id    = id;
    bus.stime_alarm = st;
    bus.alarm_en_in = en;
    bus.snooze      = snz;
    bus.stop        = stp;
    tagQ.push_back(tag);
    expQ.push_back(e);
    @(posedge clk);
    #1;
    bus.sec_tick  = 1'b0;
    bus.set_alarm = 1'b0;
    bus.snooze    = 1'b0;
    bus.stop      = 1'b0;
    checkOutput();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [19:0] t0730, t1200, tOther;
    total = 0;
    bad   = 0;
    t0730  = hms(7, 30, 0);
    t1200  = hms(12, 0, 0);
    tOther = hms(7, 30, 5);

    rst             = 1'b1;
    bus.sec_tick    = 1'b0;
    bus.hh_mm_ss    = '0;
    bus.set_alarm   = 1'b0;
    bus.alarm_id    = 2'd0;
    bus.stime_alarm = '0;
    bus.alarm_en_in = 1'b0;
    bus.snooze      = 1'b0;
    bus.stop        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkNow("reset_state", ex(0, 0, 2'd0, 4'b0000));
    rst = 1'b0;

    // Slot 1 = 07:30 enabled; off-second tick must not ring, on-second tick must.
    applyStimulus("write_slot1", 0, '0, 1, 2'd1, t0730, 1, 0, 0, ex(0, 0, 2'd0, 4'b0010));
    applyStimulus("tick_073001", 1, hms(7, 30, 1), 0, 2'd0, '0, 0, 0, 0, ex(0, 0, 2'd0, 4'b0010));
    applyStimulus("tick_073000", 1, t0730, 0, 2'd0, '0, 0, 0, 0, ex(1, 0, 2'd1, 4'b0010));

    for (int i = 1; i <= 59; i++) begin
      applyStimulus("ring_hold", 1, tOther, 0, 2'd0, '0, 0, 0, 0, ex(1, 0, 2'd1, 4'b0010));
    end
    applyStimulus("ring_timeout60", 1, tOther, 0, 2'd0, '0, 0, 0, 0, ex(0, 0, 2'd1, 4'b0010));
    applyStimulus("idle_stop_noop", 0, tOther, 0, 2'd0, '0, 0, 1, 1, ex(0, 0, 2'd1, 4'b0010));

    // Snooze for 300 ticks, then re-ring on the same slot and stop.
    applyStimulus("retrigger", 1, t0730, 0, 2'd0, '0, 0, 0, 0, ex(1, 0, 2'd1, 4'b0010));
    applyStimulus("snooze_enter", 0, tOther, 0, 2'd0, '0, 0, 1, 0, ex(0, 1, 2'd1, 4'b0010));
    applyStimulus("snooze_ignored", 0, tOther, 0, 2'd0, '0, 0, 1, 0, ex(0, 1, 2'd1, 4'b0010));
    for (int i = 1; i <= 299; i++) begin
      applyStimulus("snooze_hold", 1, tOther, 0, 2'd0, '0, 0, 0, 0, ex(0, 1, 2'd1, 4'b0010));
    end
    applyStimulus("snooze_rering", 1, tOther, 0, 2'd0, '0, 0, 0, 0, ex(1, 0, 2'd1, 4'b0010));
    applyStimulus("stop_ring", 0, tOther, 0, 2'd0, '0, 0, 0, 1, ex(0, 0, 2'd1, 4'b0010));

    // Slots 0 and 2 at 12:00: lowest index wins; later matches while ringing are ignored.
    applyStimulus("write_slot0", 0, tOther, 1, 2'd0, t1200, 1, 0, 0, ex(0, 0, 2'd1, 4'b0011));
    applyStimulus("write_slot2", 0, tOther, 1, 2'd2, t1200, 1, 0, 0, ex(0, 0, 2'd1, 4'b0111));
    applyStimulus("tie_lowest", 1, t1200, 0, 2'd0, '0, 0, 0, 0, ex(1, 0, 2'd0, 4'b0111));
    applyStimulus("no_retrigger", 1, t0730, 0, 2'd0, '0, 0, 0, 0, ex(1, 0, 2'd0, 4'b0111));
    applyStimulus("stop_and_snooze", 0, tOther, 0, 2'd0, '0, 0, 1, 1, ex(0, 0, 2'd0, 4'b0111));

    // Disabled slots at 12:00 must stay silent.
    applyStimulus("disable_slot0", 0, tOther, 1, 2'd0, t1200, 0, 0, 0, ex(0, 0, 2'd0, 4'b0110));
    applyStimulus("disable_slot2", 0, tOther, 1, 2'd2, t1200, 0, 0, 0, ex(0, 0, 2'd0, 4'b0010));
    applyStimulus("disabled_no_ring", 1, t1200, 0, 2'd0, '0, 0, 0, 0, ex(0, 0, 2'd0, 4'b0010));

    // Writes to another slot leave the ring alone; disabling the active slot beats snooze.
    applyStimulus("enable_slot2", 0, tOther, 1, 2'd2, t1200, 1, 0, 0, ex(0, 0, 2'd0, 4'b0110));
    applyStimulus("ring_slot2", 1, t1200, 0, 2'd0, '0, 0, 0, 0, ex(1, 0, 2'd2, 4'b0110));
    applyStimulus("other_slot_write", 0, tOther, 1, 2'd3, t1200, 0, 0, 0, ex(1, 0, 2'd2, 4'b0110));
    applyStimulus("disable_active", 0, tOther, 1, 2'd2, t1200, 0, 1, 0, ex(0, 0, 2'd2, 4'b0010));

    // Async reset in the middle of a snooze.
    applyStimulus("ring_for_reset", 1, t0730, 0, 2'd0, '0, 0, 0, 0, ex(1, 0, 2'd1, 4'b0010));
    applyStimulus("snooze_for_reset", 0, tOther, 0, 2'd0, '0, 0, 1, 0, ex(0, 1, 2'd1, 4'b0010));
    #1;
    rst = 1'b1;
    #1;
    checkNow("async_reset", ex(0, 0, 2'd0, 4'b0000));
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("cleared_no_ring", 1, t0730, 0, 2'd0, '0, 0, 0, 0, ex(0, 0, 2'd0, 4'b0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
